// File: rtl/epipe_pkt_reader_if.sv
// Bus bundle for the epipe egress packet reader: scheduler metadata, packet-buffer
// RAM, output FIFO, freed-id return and the packet/error counters.
interface epipe_pkt_reader_if;
    logic [7:0]   in_md;
    logic         in_md_wr;
    logic         out_pkt_valid;
    logic         out_ram_rd;
    logic [14:0]  out_ram_addr;
    logic [133:0] in_ram_rdata;
    logic [7:0]   in_pktout_usedw;
    logic [133:0] out_pkt;
    logic         out_pkt_wr;
    logic [7:0]   out_free_id;
    logic         out_free_id_wr;
    logic [63:0]  out_pkt_cnt;
    logic [31:0]  out_err_cnt;

    modport slave (
        input  in_md, in_md_wr, in_ram_rdata, in_pktout_usedw,
        output out_pkt_valid, out_ram_rd, out_ram_addr, out_pkt, out_pkt_wr,
        output out_free_id, out_free_id_wr, out_pkt_cnt, out_err_cnt
    );

    modport master (
        output in_md, in_md_wr, in_ram_rdata, in_pktout_usedw,
        input  out_pkt_valid, out_ram_rd, out_ram_addr, out_pkt, out_pkt_wr,
        input  out_free_id, out_free_id_wr, out_pkt_cnt, out_err_cnt
    );
endinterface

// File: rtl/epipe_pkt_reader.sv
// Egress packet reader: takes one buffer id from the scheduler, streams that packet
// out of the packet-buffer RAM into the output FIFO, then returns the buffer id.
//
// state | meaning
// IDLE  | ready for the next buffer id (unless the output FIFO is over threshold)
// READ  | issuing RAM reads and forwarding returned words until the tail
// FREE  | one cycle: hand the buffer id back and count the packet
module epipe_pkt_reader #(
    parameter logic [7:0] THRESH = 8'd160
) (
    input logic clk,
    input logic rst_n,
    epipe_pkt_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, FREE} state_t;

    state_t       state_q, state_d;
    logic [7:0]   id_q, id_d;
    logic [6:0]   off_q, off_d;
    logic [6:0]   rd_off_q;
    logic         rd_d1_q;
    logic [133:0] pkt_q, pkt_d;
    logic         pkt_wr_q;
    logic [63:0]  pkt_cnt_q;
    logic [31:0]  err_cnt_q;

    logic       stall, pkt_valid, md_drop;
    logic       ram_rd, free_wr;
    logic       tail_seen, overlen, bad_head;
    logic [1:0] flags;

    always_comb begin
        stall     = bus.in_pktout_usedw > THRESH;
        pkt_valid = (state_q == IDLE) && !stall;
        md_drop   = bus.in_md_wr && !pkt_valid;
        flags     = bus.in_ram_rdata[133:132];
        tail_seen = rd_d1_q && (flags == 2'b10);
        // rd_off_q is the offset of the word now on in_ram_rdata
        overlen   = rd_d1_q && (rd_off_q == 7'd95) && (flags != 2'b10);
        bad_head  = rd_d1_q && (rd_off_q == 7'd0) && (flags != 2'b01);
        pkt_d     = bus.in_ram_rdata;
        if (overlen) begin
            pkt_d[133:132] = 2'b10;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        off_d   = off_q;
        ram_rd  = 1'b0;
        free_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_md_wr && pkt_valid) begin
                    id_d    = bus.in_md;
                    off_d   = 7'd0;
                    state_d = READ;
                end
            end
            READ: begin
                ram_rd = !stall && !tail_seen && (off_q != 7'd96);
                if (ram_rd) begin
                    off_d = off_q + 7'd1;
                end
                if (tail_seen || overlen) begin
                    state_d = FREE;
                end
            end
            FREE: begin
                free_wr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            id_q      <= 8'd0;
            off_q     <= 7'd0;
            rd_off_q  <= 7'd0;
            rd_d1_q   <= 1'b0;
            pkt_q     <= '0;
            pkt_wr_q  <= 1'b0;
            pkt_cnt_q <= 64'd0;
            err_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            off_q     <= off_d;
            rd_off_q  <= off_q;
            rd_d1_q   <= ram_rd;
            pkt_wr_q  <= rd_d1_q;
            if (rd_d1_q) begin
                pkt_q <= pkt_d;
            end
            pkt_cnt_q <= pkt_cnt_q + 64'(free_wr);
            err_cnt_q <= err_cnt_q + 32'(md_drop) + 32'(bad_head) + 32'(overlen);
        end
    end

    assign bus.out_pkt_valid  = pkt_valid;
    assign bus.out_ram_rd     = ram_rd;
    assign bus.out_ram_addr   = {id_q, off_q};
    assign bus.out_pkt        = pkt_q;
    assign bus.out_pkt_wr     = pkt_wr_q;
    assign bus.out_free_id    = free_wr ? id_q : 8'd0;
    assign bus.out_free_id_wr = free_wr;
    assign bus.out_pkt_cnt    = pkt_cnt_q;
    assign bus.out_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_epipe_pkt_reader.sv
// Self-checking bench for epipe_pkt_reader: behavioural packet-buffer RAM, expected
// word queue filled when a packet is launched and drained against the observed words.
module tb_epipe_pkt_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    epipe_pkt_reader_if bus ();

    epipe_pkt_reader #(.THRESH(8'd160)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // packet shape per buffer id; length 0 means the RAM never returns a tail
    int unsigned plen [256];
    bit          badh [256];

    function automatic logic [133:0] ram_word(input logic [14:0] a);
        logic [1:0] f;
        int unsigned off;
        int unsigned id;
        off = a[6:0];
        id  = a[14:7];
        if (off == 0)                                   f = badh[id] ? 2'b11 : 2'b01;
        else if (plen[id] != 0 && off == plen[id] - 1) f = 2'b10;
        else                                            f = 2'b11;
        return {f, a, 117'(a) * 117'd2654435761};
    endfunction

    always @(posedge clk) begin
        if (bus.out_ram_rd) bus.in_ram_rdata <= ram_word(bus.out_ram_addr);
    end

    logic [133:0] exp_q [$];
    logic [133:0] obs_q [$];
    logic [14:0]  rd_q  [$];
    logic [7:0]   free_q [$];
    int           wr_cyc;
    logic [133:0] sb_got, sb_want;

    task automatic tick(input logic wr, input logic [7:0] md, input logic [7:0] uw);
        @(negedge clk);
        bus.in_md_wr        = wr;
        bus.in_md           = md;
        bus.in_pktout_usedw = uw;
        #1;
        if (rst_n) begin
            if (bus.out_pkt_wr)     begin obs_q.push_back(bus.out_pkt); wr_cyc = cyc; end
            if (bus.out_ram_rd)     rd_q.push_back(bus.out_ram_addr);
            if (bus.out_free_id_wr) free_q.push_back(bus.out_free_id);
        end
    endtask

    task automatic clear_logs();
        exp_q.delete(); obs_q.delete(); rd_q.delete(); free_q.delete();
    endtask

    task automatic push_pkt(input logic [7:0] id, input int n, input bit overlength);
        logic [133:0] w;
        for (int k = 0; k < n; k++) begin
            w = ram_word({id, 7'(k)});
            if (overlength && k == n - 1) w[133:132] = 2'b10;
            exp_q.push_back(w);
        end
    endtask

    // pairs expected and observed words in order; returns the number of disagreements
    task automatic sb_drain(output int bad);
        logic [133:0] e, o;
        bad = (exp_q.size() != obs_q.size()) ? 1 : 0;
        sb_got = '0; sb_want = '0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o !== e) begin
                if (bad == 0) begin sb_got = o; sb_want = e; end
                bad++;
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic wait_free(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick(1'b0, 8'd0, 8'd0);
            if (bus.out_free_id_wr) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(1'b0, 8'd0, 8'd0);
        tick(1'b0, 8'd0, 8'd0);
        checks++;
        if ({bus.out_ram_rd, bus.out_pkt_wr, bus.out_free_id_wr, bus.out_free_id, bus.out_ram_addr,
             bus.out_pkt, bus.out_pkt_cnt, bus.out_err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got pkt=%h cnt=%0d err=%0d rd=%b want all zero",
                     bus.out_pkt, bus.out_pkt_cnt, bus.out_err_cnt, bus.out_ram_rd);
        end
        checks++;
        if (bus.out_pkt_valid !== 1'b1) begin
            errors++; $display("FAIL reset_valid got %b want 1", bus.out_pkt_valid);
        end
        rst_n = 1'b1;
        tick(1'b0, 8'd0, 8'd0);
    endtask

    task automatic test_basic();
        int t, bad;
        logic [63:0] p0;
        logic [31:0] e0;
        clear_logs();
        plen[8'h05] = 4;
        push_pkt(8'h05, 4, 1'b0);
        p0 = bus.out_pkt_cnt; e0 = bus.out_err_cnt;
        tick(1'b1, 8'h05, 8'd0);
        t = cyc;
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 8'd0, 8'd0);
            checks++;
            if (bus.out_ram_rd !== 1'b1 || bus.out_ram_addr !== {8'h05, 7'(k - 1)} || bus.out_pkt_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_read T+%0d got rd=%b addr=%h valid=%b want rd=1 addr=%h valid=0",
                         k, bus.out_ram_rd, bus.out_ram_addr, bus.out_pkt_valid, {8'h05, 7'(k - 1)});
            end
        end
        tick(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.out_ram_rd !== 1'b0 || bus.out_pkt_valid !== 1'b0) begin
            errors++; $display("FAIL basic_no_overread got rd=%b valid=%b want 0 0", bus.out_ram_rd, bus.out_pkt_valid);
        end
        tick(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.out_free_id_wr !== 1'b1 || bus.out_free_id !== 8'h05 || bus.out_pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_free T+6 got wr=%b id=%h valid=%b want 1 05 0",
                     bus.out_free_id_wr, bus.out_free_id, bus.out_pkt_valid);
        end
        checks++;
        if (wr_cyc !== t + 6) begin
            errors++; $display("FAIL basic_tail_write got cycle T+%0d want T+6", wr_cyc - t);
        end
        tick(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.out_pkt_valid !== 1'b1 || bus.out_pkt_cnt !== p0 + 64'd1 || bus.out_err_cnt !== e0) begin
            errors++;
            $display("FAIL basic_done got valid=%b pkt_cnt=%0d err=%0d want 1 %0d %0d",
                     bus.out_pkt_valid, bus.out_pkt_cnt, bus.out_err_cnt, p0 + 64'd1, e0);
        end
        sb_drain(bad);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL basic_words bad=%0d got %h want %h", bad, sb_got, sb_want);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bit ok;
        clear_logs();
        plen[8'h07] = 3;
        push_pkt(8'h07, 3, 1'b0);
        tick(1'b1, 8'h07, 8'd0);
        tick(1'b0, 8'd0, 8'd0);
        for (int k = 2; k <= 4; k++) begin
            tick(1'b0, 8'd0, 8'd161);
            checks++;
            if (bus.out_ram_rd !== 1'b0) begin
                errors++; $display("FAIL bp_stall_read T+%0d got rd=%b want 0", k, bus.out_ram_rd);
            end
        end
        wait_free(12, ok);
        tick(1'b0, 8'd0, 8'd0);
        tick(1'b0, 8'd0, 8'd0);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_free_timeout got none want free id 07"); end
        checks++;
        if (rd_q.size() != 3 || rd_q[0] !== {8'h07, 7'd0} || rd_q[1] !== {8'h07, 7'd1} || rd_q[2] !== {8'h07, 7'd2}) begin
            errors++; $display("FAIL bp_read_addrs got %0d reads want 3 at 0380..0382", rd_q.size());
        end
        checks++;
        if (free_q.size() != 1) begin
            errors++; $display("FAIL bp_free_once got %0d frees want 1", free_q.size());
        end
        sb_drain(bad);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_words bad=%0d got %h want %h", bad, sb_got, sb_want);
        end
    endtask

    task automatic test_idle_threshold();
        logic [31:0] e0;
        clear_logs();
        e0 = bus.out_err_cnt;
        tick(1'b0, 8'd0, 8'd160);
        checks++;
        if (bus.out_pkt_valid !== 1'b1) begin
            errors++; $display("FAIL thresh_at_160 got valid=%b want 1", bus.out_pkt_valid);
        end
        tick(1'b0, 8'd0, 8'd161);
        checks++;
        if (bus.out_pkt_valid !== 1'b0) begin
            errors++; $display("FAIL thresh_at_161 got valid=%b want 0", bus.out_pkt_valid);
        end
        tick(1'b1, 8'h0A, 8'd161);
        tick(1'b0, 8'd0, 8'd0);
        tick(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.out_err_cnt !== e0 + 32'd1 || rd_q.size() != 0 || bus.out_pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL thresh_drop got err=%0d reads=%0d valid=%b want err=%0d reads=0 valid=1",
                     bus.out_err_cnt, rd_q.size(), bus.out_pkt_valid, e0 + 32'd1);
        end
    endtask

    task automatic test_busy_drop();
        int bad, wrong_id;
        bit ok;
        logic [31:0] e0;
        clear_logs();
        plen[8'h03] = 4;
        push_pkt(8'h03, 4, 1'b0);
        e0 = bus.out_err_cnt;
        tick(1'b1, 8'h03, 8'd0);
        tick(1'b0, 8'd0, 8'd0);
        tick(1'b1, 8'h09, 8'd0);
        wait_free(12, ok);
        tick(1'b0, 8'd0, 8'd0);
        tick(1'b0, 8'd0, 8'd0);
        wrong_id = 0;
        foreach (rd_q[i]) if (rd_q[i] !== {8'h03, 7'(i)}) wrong_id++;
        checks++;
        if (!ok || free_q.size() != 1 || free_q[0] !== 8'h03) begin
            errors++; $display("FAIL busy_free got ok=%b frees=%0d want one free of id 03", ok, free_q.size());
        end
        checks++;
        if (rd_q.size() != 4 || wrong_id != 0) begin
            errors++; $display("FAIL busy_reads got %0d reads %0d misaddressed want 4 0", rd_q.size(), wrong_id);
        end
        checks++;
        if (bus.out_err_cnt !== e0 + 32'd1 || bus.out_pkt_valid !== 1'b1) begin
            errors++; $display("FAIL busy_err got err=%0d valid=%b want %0d 1", bus.out_err_cnt, bus.out_pkt_valid, e0 + 32'd1);
        end
        sb_drain(bad);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL busy_words bad=%0d got %h want %h", bad, sb_got, sb_want);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bit ok;
        logic [31:0] e0;
        clear_logs();
        plen[8'h0C] = 2;
        plen[8'h0E] = 2;
        push_pkt(8'h0C, 2, 1'b0);
        push_pkt(8'h0E, 2, 1'b0);
        e0 = bus.out_err_cnt;
        tick(1'b1, 8'h0C, 8'd0);
        repeat (3) tick(1'b0, 8'd0, 8'd0);
        tick(1'b1, 8'h0D, 8'd0);
        checks++;
        if (bus.out_free_id_wr !== 1'b1 || bus.out_free_id !== 8'h0C || bus.out_pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_free_cycle got wr=%b id=%h valid=%b want 1 0c 0",
                     bus.out_free_id_wr, bus.out_free_id, bus.out_pkt_valid);
        end
        tick(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.out_pkt_valid !== 1'b1 || bus.out_err_cnt !== e0 + 32'd1) begin
            errors++;
            $display("FAIL b2b_drop got valid=%b err=%0d want 1 %0d", bus.out_pkt_valid, bus.out_err_cnt, e0 + 32'd1);
        end
        tick(1'b1, 8'h0E, 8'd0);
        wait_free(10, ok);
        tick(1'b0, 8'd0, 8'd0);
        checks++;
        if (!ok || free_q.size() != 2 || free_q[1] !== 8'h0E || rd_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_second got ok=%b frees=%0d reads=%0d want 1 2 4", ok, free_q.size(), rd_q.size());
        end
        sb_drain(bad);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL b2b_words bad=%0d got %h want %h", bad, sb_got, sb_want);
        end
    endtask

    task automatic test_bad_head();
        int bad;
        bit ok;
        logic [63:0] p0;
        logic [31:0] e0;
        clear_logs();
        plen[8'h22] = 2;
        badh[8'h22] = 1'b1;
        push_pkt(8'h22, 2, 1'b0);
        p0 = bus.out_pkt_cnt; e0 = bus.out_err_cnt;
        tick(1'b1, 8'h22, 8'd0);
        wait_free(10, ok);
        tick(1'b0, 8'd0, 8'd0);
        checks++;
        if (!ok || bus.out_err_cnt !== e0 + 32'd1 || bus.out_pkt_cnt !== p0 + 64'd1) begin
            errors++;
            $display("FAIL badhead_counts got ok=%b err=%0d pkt=%0d want 1 %0d %0d",
                     ok, bus.out_err_cnt, bus.out_pkt_cnt, e0 + 32'd1, p0 + 64'd1);
        end
        sb_drain(bad);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL badhead_words bad=%0d got %h want %h", bad, sb_got, sb_want);
        end
    endtask

    task automatic test_overlength();
        int bad, misaddr;
        bit ok;
        logic [31:0] e0;
        clear_logs();
        plen[8'h11] = 0;
        push_pkt(8'h11, 96, 1'b1);
        e0 = bus.out_err_cnt;
        tick(1'b1, 8'h11, 8'd0);
        wait_free(120, ok);
        tick(1'b0, 8'd0, 8'd0);
        tick(1'b0, 8'd0, 8'd0);
        misaddr = 0;
        foreach (rd_q[i]) if (rd_q[i] !== {8'h11, 7'(i)}) misaddr++;
        checks++;
        if (rd_q.size() != 96 || misaddr != 0) begin
            errors++; $display("FAIL overlen_reads got %0d reads %0d misaddressed want 96 0", rd_q.size(), misaddr);
        end
        checks++;
        if (!ok || free_q.size() != 1 || free_q[0] !== 8'h11 || bus.out_err_cnt !== e0 + 32'd1) begin
            errors++;
            $display("FAIL overlen_free got ok=%b frees=%0d err=%0d want 1 1 %0d", ok, free_q.size(), bus.out_err_cnt, e0 + 32'd1);
        end
        sb_drain(bad);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL overlen_words bad=%0d got %h want %h", bad, sb_got, sb_want);
        end
    endtask

    task automatic test_reset_mid_packet();
        int bad;
        bit ok;
        clear_logs();
        plen[8'h33] = 8;
        push_pkt(8'h33, 1, 1'b0);
        tick(1'b1, 8'h33, 8'd0);
        repeat (3) tick(1'b0, 8'd0, 8'd0);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_ram_rd, bus.out_pkt_wr, bus.out_free_id_wr, bus.out_free_id, bus.out_ram_addr,
             bus.out_pkt, bus.out_pkt_cnt, bus.out_err_cnt} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got pkt=%h cnt=%0d err=%0d addr=%h want all zero",
                     bus.out_pkt, bus.out_pkt_cnt, bus.out_err_cnt, bus.out_ram_addr);
        end
        repeat (2) tick(1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;
        repeat (4) tick(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.out_pkt_valid !== 1'b1 || free_q.size() != 0) begin
            errors++; $display("FAIL rstmid_idle got valid=%b frees=%0d want 1 0", bus.out_pkt_valid, free_q.size());
        end
        sb_drain(bad);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rstmid_words bad=%0d got %h want %h", bad, sb_got, sb_want);
        end
        clear_logs();
        plen[8'h33] = 3;
        push_pkt(8'h33, 3, 1'b0);
        tick(1'b1, 8'h33, 8'd0);
        tick(1'b0, 8'd0, 8'd0);
        checks++;
        if (bus.out_ram_rd !== 1'b1 || bus.out_ram_addr !== {8'h33, 7'd0}) begin
            errors++; $display("FAIL rstmid_restart got rd=%b addr=%h want 1 %h", bus.out_ram_rd, bus.out_ram_addr, {8'h33, 7'd0});
        end
        wait_free(10, ok);
        tick(1'b0, 8'd0, 8'd0);
        sb_drain(bad);
        checks++;
        if (!ok || bad != 0 || bus.out_pkt_cnt !== 64'd1) begin
            errors++;
            $display("FAIL rstmid_next got ok=%b bad=%0d pkt_cnt=%0d want 1 0 1", ok, bad, bus.out_pkt_cnt);
        end
    endtask

    initial begin
        bus.in_md           = 8'd0;
        bus.in_md_wr        = 1'b0;
        bus.in_pktout_usedw = 8'd0;
        test_reset();
        test_basic();
        test_backpressure();
        test_idle_threshold();
        test_busy_drop();
        test_back_to_back();
        test_bad_head();
        test_overlength();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
